// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory line responder.
// Optional build macro: DMEM_RANGE_CHECK_EN (see dmem_line_responder).
package dmem_pkg;

  localparam int LINE_W     = 256;
  localparam int OFFSET_W   = 5;
  localparam int ADDR_W     = 32;
  localparam int LINE_NUM_W = ADDR_W - OFFSET_W;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  // The index field keeps the full line number so range checks can see
  // bits above the storage depth; storage uses only the low bits.
  typedef struct packed {
    logic                  write;
    logic [LINE_NUM_W-1:0] index;
    logic [LINE_W-1:0]     data;
  } req_t;

  function automatic logic [LINE_NUM_W-1:0] line_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:OFFSET_W];
  endfunction

endpackage

// File: rtl/dmem_line_array.sv
// Line storage for the responder: MEM_LINES x 256-bit, one synchronous
// write port and one registered read port sharing a single index.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int MEM_LINES = 512,
  localparam int IDX_W    = $clog2(MEM_LINES)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              wr_en_i,
  input  logic [LINE_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic              rd_clr_i,
  output logic [LINE_W-1:0] rd_data_o
);

  logic [LINE_W-1:0] mem_q [MEM_LINES];
  logic [LINE_W-1:0] rd_data_q;

  // NOTE: the storage array has no reset; clearing it would need a reset
  // port on every word and would stop it mapping onto RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[idx_i] <= wr_data_i;
    end
  end

  // The read register is ordinary state: it resets so data_o starts at 0
  // and it holds between reads.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= rd_clr_i ? '0 : mem_q[idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dmem_line_responder.sv
// Main-memory model answering whole-line refill/write-back requests with a
// fixed latency. Optional macro DMEM_RANGE_CHECK_EN flags out-of-range lines.
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int MEM_LINES = 512,
  parameter int LATENCY   = 10
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int              IDX_W    = $clog2(MEM_LINES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q;
  req_t             in_req;
  req_t             act_req;
  logic             accept;
  logic             ack_entry;
  logic             act_flag;

  assign in_req = '{write: write_i, index: line_of(addr_i), data: data_i};

  // With LATENCY=1 the accepting edge is also the ACK-entry edge, so the
  // array must see the live inputs rather than the (not yet loaded) latch.
  assign act_req = (state_q == IDLE) ? in_req : req_q;

  // NOTE: every always_comb output gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    ack_entry = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          accept = 1'b1;
          cnt_d  = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d   = ACK;
            ack_entry = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d   = ACK;
          ack_entry = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request payload is only meaningful after acceptance, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_q <= in_req;
    end
  end

`ifdef DMEM_RANGE_CHECK_EN
  logic flag_q;
  logic flag_in;

  assign flag_in  = (in_req.index >= LINE_NUM_W'(MEM_LINES));
  assign act_flag = (state_q == IDLE) ? flag_in : flag_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      flag_q <= 1'b0;
    end else if (accept) begin
      flag_q <= flag_in;
    end
  end

  assign err_o = (state_q == ACK) && flag_q;
`else
  assign act_flag = 1'b0;
  assign err_o    = 1'b0;
`endif

  dmem_line_array #(
    .MEM_LINES (MEM_LINES)
  ) u_array (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .idx_i     (act_req.index[IDX_W-1:0]),
    .wr_en_i   (ack_entry && act_req.write && !act_flag),
    .wr_data_i (act_req.data),
    .rd_en_i   (ack_entry && !act_req.write),
    .rd_clr_i  (act_flag),
    .rd_data_o (data_o)
  );

  assign ack_o  = (state_q == ACK);
  assign busy_o = (state_q != IDLE);

endmodule
